// File: rtl/fir_avg_pkg.sv
// fir_avg_pkg: shared constants, pipe record and averaging helper for the FIR averaging stage
package fir_avg_pkg;

    localparam int FIR_LAT   = 2;
    localparam int TAPS      = 4;
    localparam int LOG2_TAPS = 2;
    localparam int DROP_W    = 8;

    // One stage of the qualifier pipe that tracks the FIR data path
    typedef struct packed {
        logic v;
        logic win;
    } pipe_t;

    // Divide a tap sum by TAPS, rounding half up when round is set
    function automatic logic [31:0] avg_round(input logic [31:0] sum, input logic round);
        return round ? (sum + 32'(TAPS / 2)) >> LOG2_TAPS : sum >> LOG2_TAPS;
    endfunction

endpackage

// File: rtl/fir_avg_fifo.sv
// fir_avg_fifo: synchronous W x DEPTH FIFO with wrap-bit pointers
module fir_avg_fifo
    import fir_avg_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    // A push into a full FIFO is taken when the head leaves in the same cycle
    always_comb begin
        full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        empty   = wptr == rptr;
        do_push = push && (!full || pop);
        do_pop  = pop && !empty;
        rdata   = mem[rptr[AW-1:0]];
    end

    // Storage and pointers; memory is cleared so the head reads zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/fir4_avg_out.sv
// fir4_avg_out: aligns valid to the 4-tap FIR, averages the sum and streams it out through a FIFO
module fir4_avg_out
    import fir_avg_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 2,
    parameter int ROUND = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [W+1:0]      fir_sum,
    output logic [W-1:0]      m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              warm,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic [DROP_W-1:0] drop_cnt
);

    logic [2:0]               run;
    logic [2:0]               run_next;
    logic                     win_now;
    pipe_t [FIR_LAT-1:0]      pipe;
    logic                     res_v;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic                     drop;
    logic [W-1:0]             avg;

    // Run length including the current cycle decides whether the window is all real samples
    always_comb begin
        run_next = in_valid ? ((run >= 3'(TAPS)) ? 3'(TAPS) : run + 3'd1) : 3'd0;
        win_now  = run_next >= 3'(TAPS);
        res_v    = pipe[FIR_LAT-1].v && pipe[FIR_LAT-1].win;
        warm     = pipe[FIR_LAT-1].win;
        avg      = W'(avg_round(32'(fir_sum), ROUND != 0));
        m_valid  = !empty;
        pop      = m_valid && m_ready;
        drop     = res_v && full && !pop;
    end

    // Run counter and the qualifier pipe that matches the FIR latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run  <= '0;
            pipe <= '0;
        end else begin
            run  <= run_next;
            pipe <= {pipe[FIR_LAT-2:0], pipe_t'{v: in_valid, win: win_now}};
        end
    end

    // Drop accounting; a drop in the same cycle as a clear restarts the count at one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= ovf_clr ? DROP_W'(1) : (&drop_cnt ? drop_cnt : drop_cnt + 1'b1);
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    fir_avg_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (res_v),
        .pop   (pop),
        .wdata (avg),
        .rdata (m_data),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_fir4_avg_out.sv
// tb_fir4_avg_out: directed table and corner sequences for the FIR averaging output stage
module tb_fir4_avg_out;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic        m_ready;
    logic        ovf_clr;
    logic [17:0] fir_sum = '0;
    logic [15:0] x [4] = '{default: '0};

    logic [15:0] m_data, m_data0;
    logic        m_valid, m_valid0;
    logic        warm, warm0;
    logic        overflow, overflow0;
    logic [7:0]  drop_cnt, drop_cnt0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        iv;
        logic [15:0] a;
        logic        rdy;
        logic        clr;
        logic        mv;
        logic [15:0] md;
        logic        wm;
        logic        ov;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl [19];

    always #5 clk = ~clk;

    // Stand-in for the upstream FIR: tap registers then a registered sum
    always @(posedge clk) begin
        x[0]    <= a;
        x[1]    <= x[0];
        x[2]    <= x[1];
        x[3]    <= x[2];
        fir_sum <= 18'(x[0]) + 18'(x[1]) + 18'(x[2]) + 18'(x[3]);
    end

    fir4_avg_out #(.W(16), .DEPTH(2), .ROUND(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .fir_sum(fir_sum),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .warm(warm),
        .overflow(overflow), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
    );

    fir4_avg_out #(.W(16), .DEPTH(2), .ROUND(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .fir_sum(fir_sum),
        .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready), .warm(warm0),
        .overflow(overflow0), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt0)
    );

    function automatic vec_t mk(input int iv, input int av, input int rdy, input int clr,
                                input int mv, input int md, input int wm, input int ov, input int cnt);
        vec_t v;
        v.iv = 1'(iv); v.a = 16'(av); v.rdy = 1'(rdy); v.clr = 1'(clr);
        v.mv = 1'(mv); v.md = 16'(md); v.wm = 1'(wm); v.ov = 1'(ov); v.cnt = 8'(cnt);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic iv, input logic [15:0] av, input logic rdy, input logic clr);
        @(posedge clk);
        #1;
        in_valid = iv;
        a        = av;
        m_ready  = rdy;
        ovf_clr  = clr;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        m_ready  = 1'b0;
        ovf_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; m_ready = 1'b0; ovf_clr = 1'b0;

        for (int c = 0; c < 5; c++) tbl[c] = mk(1, 100, 1, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 100, 1, 0, 0, 0,   1, 0, 0);
        tbl[6]  = mk(1, 100, 1, 0, 1, 100, 1, 0, 0);
        tbl[7]  = mk(1, 100, 1, 0, 1, 100, 1, 0, 0);
        tbl[8]  = mk(1, 100, 1, 0, 1, 100, 1, 0, 0);
        tbl[9]  = mk(1, 100, 0, 0, 1, 100, 1, 0, 0);
        tbl[10] = mk(1, 100, 0, 0, 1, 100, 1, 0, 0);
        tbl[11] = mk(1, 100, 0, 0, 1, 100, 1, 1, 1);
        tbl[12] = mk(1, 100, 0, 0, 1, 100, 1, 1, 2);
        tbl[13] = mk(1, 100, 0, 0, 1, 100, 1, 1, 3);
        tbl[14] = mk(1, 100, 0, 1, 1, 100, 1, 1, 4);
        tbl[15] = mk(1, 100, 0, 0, 1, 100, 1, 1, 1);
        tbl[16] = mk(1, 100, 1, 1, 1, 100, 1, 1, 2);
        tbl[17] = mk(1, 100, 1, 0, 1, 100, 1, 0, 0);
        tbl[18] = mk(1, 100, 1, 0, 1, 100, 1, 0, 0);

        reset_dut();
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_warm", 32'(warm), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);

        for (int i = 0; i < 19; i++) begin
            apply(tbl[i].iv, tbl[i].a, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].mv));
            chk($sformatf("v%0d_m_data", i), 32'(m_data), 32'(tbl[i].md));
            chk($sformatf("v%0d_m_data_trunc", i), 32'(m_data0), 32'(tbl[i].md));
            chk($sformatf("v%0d_warm", i), 32'(warm), 32'(tbl[i].wm));
            chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(tbl[i].ov));
            chk($sformatf("v%0d_drop_cnt", i), 32'(drop_cnt), 32'(tbl[i].cnt));
        end

        apply(0, 100, 1, 0);
        apply(1, 100, 1, 0);
        chk("gap_warm_hold", 32'(warm), 1);
        apply(1, 100, 1, 0);
        chk("gap_warm_fall", 32'(warm), 0);
        apply(1, 100, 1, 0);
        apply(1, 100, 1, 0);
        chk("gap_drained", 32'(m_valid), 0);
        apply(1, 100, 1, 0);
        chk("gap_warm_low", 32'(warm), 0);
        apply(1, 100, 1, 0);
        chk("gap_warm_back", 32'(warm), 1);
        chk("gap_no_early_result", 32'(m_valid), 0);
        apply(1, 100, 0, 0);
        chk("gap_result", 32'(m_valid), 1);
        chk("gap_data", 32'(m_data), 100);
        apply(1, 100, 0, 0);
        apply(1, 100, 0, 0);
        chk("pre_rst_overflow", 32'(overflow), 1);
        chk("pre_rst_drop_cnt", 32'(drop_cnt), 1);

        rst_n = 1'b0;
        #1;
        chk("async_rst_m_valid", 32'(m_valid), 0);
        chk("async_rst_overflow", 32'(overflow), 0);
        chk("async_rst_drop_cnt", 32'(drop_cnt), 0);
        chk("async_rst_warm", 32'(warm), 0);
        reset_dut();
        for (int c = 0; c < 7; c++) begin
            apply(1, 100, 1, 0);
            if (c == 5) chk("rearm_c5_m_valid", 32'(m_valid), 0);
            if (c == 6) begin
                chk("rearm_c6_m_valid", 32'(m_valid), 1);
                chk("rearm_c6_m_data", 32'(m_data), 100);
            end
        end

        reset_dut();
        for (int c = 0; c < 8; c++) begin
            apply(c < 4, (c < 4) ? 16'(c + 1) : 16'd0, 1, 0);
            if (c == 6) begin
                chk("round_m_valid", 32'(m_valid), 1);
                chk("round_half_up", 32'(m_data), 3);
                chk("round_trunc", 32'(m_data0), 2);
            end
            if (c == 7) chk("round_single", 32'(m_valid), 0);
        end

        reset_dut();
        for (int c = 0; c < 7; c++) begin
            apply(c < 4, (c < 4) ? 16'hFFFF : 16'd0, 1, 0);
            if (c == 6) begin
                chk("full_scale_round", 32'(m_data), 32'hFFFF);
                chk("full_scale_trunc", 32'(m_data0), 32'hFFFF);
            end
        end

        reset_dut();
        for (int c = 0; c < 11; c++) begin
            apply(c < 6, (c < 6) ? 16'(10 * (c + 1)) : 16'd0, c >= 7, 0);
            if (c == 6) chk("fp_c6_data", 32'(m_data), 25);
            if (c == 7) begin
                chk("fp_c7_data", 32'(m_data), 25);
                chk("fp_c7_trunc", 32'(m_data0), 25);
            end
            if (c == 8) begin
                chk("fp_c8_m_valid", 32'(m_valid), 1);
                chk("fp_c8_data", 32'(m_data), 35);
                chk("fp_c8_overflow", 32'(overflow), 0);
                chk("fp_c8_drop_cnt", 32'(drop_cnt), 0);
            end
            if (c == 9) begin
                chk("fp_c9_m_valid", 32'(m_valid), 1);
                chk("fp_c9_data", 32'(m_data), 45);
            end
            if (c == 10) chk("fp_c10_m_valid", 32'(m_valid), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
